// File: rtl/tank_dist_sched.sv
// Single scheduler for NUM_RACKS store racks. It decodes one tank access and waits for the
// addressed word at the delay-line head, then drives one rack gate for exactly one minor cycle.
module tank_dist_sched #(
    parameter int NUM_RACKS      = 4,
    parameter int RACK_BITS      = 2,
    parameter int SEL_BITS       = 2,
    parameter int WORDS_PER_TANK = 16,
    parameter int WORD_BITS      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [RACK_BITS+SEL_BITS+WORD_BITS-1:0] req_addr,
    input  logic                                  req_write,
    input  logic                                  minor_strobe,
    input  logic [WORD_BITS-1:0]                  word_pos,
    output logic [SEL_BITS-1:0]                   f_pos,
    output logic [SEL_BITS-1:0]                   f_neg,
    output logic [NUM_RACKS-1:0]                  rack_t_in,
    output logic [NUM_RACKS-1:0]                  rack_t_out,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
);

    localparam int ADDR_W = RACK_BITS + SEL_BITS + WORD_BITS;
    localparam logic [RACK_BITS:0] RACK_LIM = (RACK_BITS+1)'(NUM_RACKS);
    localparam logic [WORD_BITS:0] WORD_LIM = (WORD_BITS+1)'(WORDS_PER_TANK);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        WAIT  = 3'd2,
        XFER  = 3'd3,
        DONE  = 3'd4,
        ABORT = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [RACK_BITS-1:0]   rack;
    logic [WORD_BITS-1:0]   word;
    logic                   write;
    logic [WORD_BITS:0]     miss;
    logic [WORD_BITS:0]     miss_nxt;
    logic                   accept;
    logic                   hit;
    logic                   addr_bad;
    logic [NUM_RACKS-1:0]   rack_hot;

    assign accept   = req_valid & req_ready;
    assign hit      = (word_pos == word);
    assign miss_nxt = miss + 1'b1;
    assign addr_bad = ({1'b0, rack} >= RACK_LIM) || ({1'b0, word} >= WORD_LIM);
    assign rack_hot = NUM_RACKS'(1) << rack;
    assign f_neg    = ~f_pos;

    // State register and request latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rack  <= '0;
            word  <= '0;
            write <= 1'b0;
            f_pos <= '0;
            miss  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rack  <= req_addr[ADDR_W-1 -: RACK_BITS];
                f_pos <= req_addr[WORD_BITS +: SEL_BITS];
                word  <= req_addr[WORD_BITS-1:0];
                write <= req_write;
            end
            if (state == CHECK)
                miss <= '0;
            else if (state == WAIT && minor_strobe && !hit)
                miss <= miss_nxt;
        end
    end

    // Next-state decode; strobes outside WAIT/XFER are deliberately ignored
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = CHECK;
            CHECK: state_nxt = addr_bad ? ABORT : WAIT;
            WAIT: begin
                if (minor_strobe) begin
                    if (hit)
                        state_nxt = XFER;
                    else if (miss_nxt == WORD_LIM)
                        state_nxt = ABORT;
                end
            end
            XFER:  if (minor_strobe) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            ABORT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode from state alone, so async reset clears gates at once
    always_comb begin
        req_ready  = (state == IDLE);
        busy       = (state != IDLE);
        done       = (state == DONE);
        err        = (state == ABORT);
        rack_t_in  = '0;
        rack_t_out = '0;
        if (state == XFER) begin
            if (write)
                rack_t_in  = rack_hot;
            else
                rack_t_out = rack_hot;
        end
    end

endmodule

// File: tb/tb_tank_dist_sched.sv
// Directed bench for tank_dist_sched: a 4-rack instance for the main flows and
// a 3-rack instance for the out-of-range rack abort.
module tb_tank_dist_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_valid3;
    logic [7:0] req_addr;
    logic       req_write;
    logic       minor_strobe;
    logic [3:0] word_pos;

    logic       req_ready, busy, done, err;
    logic [1:0] f_pos, f_neg;
    logic [3:0] rack_t_in, rack_t_out;

    logic       req_ready3, busy3, done3, err3;
    logic [1:0] f_pos3, f_neg3;
    logic [2:0] rack_t_in3, rack_t_out3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tank_dist_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write), .minor_strobe(minor_strobe),
        .word_pos(word_pos), .f_pos(f_pos), .f_neg(f_neg), .rack_t_in(rack_t_in),
        .rack_t_out(rack_t_out), .busy(busy), .done(done), .err(err)
    );

    tank_dist_sched #(.NUM_RACKS(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_addr(req_addr), .req_write(req_write), .minor_strobe(minor_strobe),
        .word_pos(word_pos), .f_pos(f_pos3), .f_neg(f_neg3), .rack_t_in(rack_t_in3),
        .rack_t_out(rack_t_out3), .busy(busy3), .done(done3), .err(err3)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] wp);
        minor_strobe = 1'b1;
        word_pos     = wp;
        tick();
        minor_strobe = 1'b0;
    endtask

    task automatic send(input logic [1:0] r, input logic [1:0] s, input logic [3:0] w, input logic wr);
        req_valid = 1'b1;
        req_addr  = {r, s, w};
        req_write = wr;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0; req_addr = '0;
        req_write = 1'b0; minor_strobe = 1'b0; word_pos = '0;
        #12;
        check_val("rst_ready", 32'(req_ready), 32'd1);
        check_val("rst_fpos",  32'(f_pos), 32'd0);
        check_val("rst_fneg",  32'(f_neg), 32'd3);
        check_val("rst_gates", 32'({rack_t_in, rack_t_out}), 32'd0);
        check_val("rst_flags", 32'({busy, done, err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Read rack 1, sel 2, word 5
        send(2'd1, 2'b10, 4'd5, 1'b0);
        check_val("rd_fpos",  32'(f_pos), 32'd2);
        check_val("rd_fneg",  32'(f_neg), 32'd1);
        check_val("rd_ready", 32'(req_ready), 32'd0);
        check_val("rd_busy",  32'(busy), 32'd1);
        tick();
        strobe(4'd3);
        strobe(4'd4);
        check_val("rd_pre_gate", 32'({rack_t_in, rack_t_out}), 32'd0);
        strobe(4'd5);
        check_val("rd_gate_out", 32'(rack_t_out), 32'b0010);
        check_val("rd_gate_in",  32'(rack_t_in), 32'd0);
        tick(); tick();
        check_val("rd_gate_hold", 32'(rack_t_out), 32'b0010);
        check_val("rd_no_done",   32'(done), 32'd0);
        strobe(4'd6);
        check_val("rd_gate_drop", 32'({rack_t_in, rack_t_out}), 32'd0);
        check_val("rd_done",      32'(done), 32'd1);
        tick();
        check_val("rd_done_pulse", 32'(done), 32'd0);
        check_val("rd_idle",       32'({req_ready, busy}), 32'b10);
        check_val("rd_fpos_hold",  32'(f_pos), 32'd2);

        // Write rack 3, word 0, strobes wrap from 15 to 0
        send(2'd3, 2'b00, 4'd0, 1'b1);
        tick();
        strobe(4'd15);
        check_val("wr_pre_gate", 32'({rack_t_in, rack_t_out}), 32'd0);
        strobe(4'd0);
        check_val("wr_gate_in",  32'(rack_t_in), 32'b1000);
        check_val("wr_gate_out", 32'(rack_t_out), 32'd0);
        strobe(4'd1);
        check_val("wr_done",      32'(done), 32'd1);
        check_val("wr_gate_drop", 32'(rack_t_in), 32'd0);
        tick();

        // Rack 3 on a 3-rack instance aborts
        req_valid3 = 1'b1; req_addr = {2'd3, 2'd1, 4'd2}; req_write = 1'b0;
        tick();
        req_valid3 = 1'b0;
        check_val("rk_check_err", 32'(err3), 32'd0);
        tick();
        check_val("rk_err",   32'(err3), 32'd1);
        check_val("rk_gates", 32'({rack_t_in3, rack_t_out3}), 32'd0);
        tick();
        check_val("rk_err_pulse", 32'(err3), 32'd0);
        check_val("rk_idle",      32'({req_ready3, busy3}), 32'b10);

        // word_pos stuck at 7 while requesting word 9
        send(2'd0, 2'd1, 4'd9, 1'b0);
        tick();
        for (int i = 0; i < 15; i++) strobe(4'd7);
        check_val("miss15_err",   32'(err), 32'd0);
        check_val("miss15_busy",  32'(busy), 32'd1);
        check_val("miss15_gates", 32'({rack_t_in, rack_t_out}), 32'd0);
        strobe(4'd7);
        check_val("miss16_err",   32'(err), 32'd1);
        check_val("miss16_gates", 32'({rack_t_in, rack_t_out}), 32'd0);
        tick();
        check_val("miss_idle", 32'({req_ready, busy, err}), 32'b100);

        // Second request held during a transfer
        send(2'd1, 2'd1, 4'd1, 1'b1);
        req_valid = 1'b1; req_addr = {2'd2, 2'd3, 4'd4}; req_write = 1'b0;
        tick();
        strobe(4'd1);
        check_val("q_fpos_kept", 32'(f_pos), 32'd1);
        check_val("q_gate_in",   32'(rack_t_in), 32'b0010);
        strobe(4'd2);
        check_val("q_done",     32'(done), 32'd1);
        check_val("q_ready_lo", 32'(req_ready), 32'd0);
        tick();
        check_val("q_ready_hi", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check_val("q_accept_busy", 32'(busy), 32'd1);
        check_val("q_accept_fpos", 32'(f_pos), 32'd3);
        tick();
        strobe(4'd4);
        check_val("q_gate_out", 32'(rack_t_out), 32'b0100);

        // Async reset while the rack 2 read gate is high
        rst = 1'b1;
        #1;
        check_val("ar_gate_drop", 32'(rack_t_out), 32'd0);
        check_val("ar_busy",      32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_val("ar_ready", 32'(req_ready), 32'd1);
        check_val("ar_idle",  32'({busy, done, err}), 32'd0);
        check_val("ar_fpos",  32'(f_pos), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
